// File: rtl/fft128_port_pkg.sv
// Shared defaults and sizing helpers for the FFT processor port bridge.
// No logic of its own; imported by the port_fifo and fft128_port files.
// Holds default widths, frame depth, the pointer-width helper and the event-counter width.
package fft128_port_pkg;

    localparam int DEF_DW_IN  = 23;
    localparam int DEF_DW_OUT = 32;
    localparam int DEF_DEPTH  = 128;
    localparam int DEF_NUIOIN = 5;
    localparam int DEF_NUIOOU = 6;

    // Width of the underflow/overflow event counters.
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Address bits needed to index DEPTH entries. Pointers carry one extra
    // MSB on top of this so that full and empty can be told apart.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/port_fifo.sv
// Show-ahead FIFO: rd_data always presents the head entry combinationally.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: a push on full and a pop on empty are ignored; callers use full/empty.
module port_fifo
    import fft128_port_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PW   = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   count
);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         push;
    logic         pop;

    // Equal pointers mean empty; equal addresses with differing wrap bits mean full.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr[PW-1:0]];

    // Pointer advance; the extra MSB makes the address wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are left as-is through reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fft128_port.sv
// Bridges a streaming source/sink to a strobe-driven FFT processor I/O port via two FIFOs.
// Latency: sample reaches io_in one cycle after acceptance; result reaches m_data one cycle after its strobe.
// Backpressure: s_ready drops when the input FIFO is full; results strobed into a full output FIFO are dropped (ovf).
// Optional macro FFT128_PORT_CNT_EN adds saturating udf_cnt/ovf_cnt event counters.
module fft128_port
    import fft128_port_pkg::*;
#(
    parameter int DW_IN    = DEF_DW_IN,
    parameter int DW_OUT   = DEF_DW_OUT,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUIOIN   = DEF_NUIOIN,
    parameter int NUIOOU   = DEF_NUIOOU,
    parameter int PORT_IN  = 0,
    parameter int PORT_OUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW_IN-1:0]  s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DW_IN-1:0]  io_in,
    input  logic [NUIOIN-1:0] req_in,
    input  logic [DW_OUT-1:0] io_out,
    input  logic [NUIOOU-1:0] out_en,
    output logic [DW_OUT-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              frame_done,
    output logic              udf,
    output logic              ovf
`ifdef FFT128_PORT_CNT_EN
   ,output logic [CNT_W-1:0]  udf_cnt,
    output logic [CNT_W-1:0]  ovf_cnt
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int FW = PW + 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(DEPTH - 1);

    logic              in_full;
    logic              in_empty;
    logic [PW:0]       in_count;
    logic [DW_IN-1:0]  in_head;
    logic              out_full;
    logic              out_empty;
    logic [PW:0]       out_count;
    logic              rd_strobe;
    logic              wr_strobe;
    logic              in_udf_evt;
    logic              out_ovf_evt;
    logic              out_accept;
    logic [FW-1:0]     frame_cnt;
    logic              unused_ok;

    // Only this block's strobe bits matter; the rest belong to other ports.
    assign rd_strobe   = req_in[PORT_IN];
    assign wr_strobe   = out_en[PORT_OUT];
    assign in_udf_evt  = rd_strobe && in_empty;
    assign out_ovf_evt = wr_strobe && out_full;
    assign out_accept  = wr_strobe && !out_full;

    assign s_ready = !in_full;
    assign io_in   = in_empty ? '0 : in_head;
    assign m_valid = !out_empty;

    assign unused_ok = ^{req_in, out_en, in_count, out_count};

    port_fifo #(.W(DW_IN), .DEPTH(DEPTH)) u_in_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s_valid),
        .wr_data (s_data),
        .rd_en   (rd_strobe),
        .rd_data (in_head),
        .full    (in_full),
        .empty   (in_empty),
        .count   (in_count)
    );

    port_fifo #(.W(DW_OUT), .DEPTH(DEPTH)) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_strobe),
        .wr_data (io_out),
        .rd_en   (m_ready),
        .rd_data (m_data),
        .full    (out_full),
        .empty   (out_empty),
        .count   (out_count)
    );

    // Sticky error flags: underflow on a read strobe while empty, overflow on a dropped write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            udf <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (in_udf_evt)  udf <= 1'b1;
            if (out_ovf_evt) ovf <= 1'b1;
        end
    end

    // Frame counter over accepted results; the DEPTH-th write pulses frame_done and wraps to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (out_accept) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt  <= '0;
                    frame_done <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

`ifdef FFT128_PORT_CNT_EN
    // Saturating event counters alongside the sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            udf_cnt <= '0;
            ovf_cnt <= '0;
        end else begin
            if (in_udf_evt && udf_cnt != CNT_MAX)  udf_cnt <= udf_cnt + 1'b1;
            if (out_ovf_evt && ovf_cnt != CNT_MAX) ovf_cnt <= ovf_cnt + 1'b1;
        end
    end
`else
    // Counter-less build: only the sticky udf/ovf flags report errors.
`endif

endmodule

// File: tb/tb_fft128_port.sv
// Directed bench for fft128_port with a queue-based reference model and per-cycle compare.
// Inputs change 1 time unit after the falling edge; outputs are sampled on the falling edge.
// Literal expectations from the hand-worked scenarios pin the model alongside it.
module tb_fft128_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [22:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [22:0] io_in;
    logic [4:0]  req_in;
    logic [31:0] io_out;
    logic [5:0]  out_en;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        frame_done;
    logic        udf;
    logic        ovf;
`ifdef FFT128_PORT_CNT_EN
    logic [15:0] udf_cnt;
    logic [15:0] ovf_cnt;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fft128_port dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .io_in      (io_in),
        .req_in     (req_in),
        .io_out     (io_out),
        .out_en     (out_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_done (frame_done),
        .udf        (udf),
        .ovf        (ovf)
`ifdef FFT128_PORT_CNT_EN
       ,.udf_cnt    (udf_cnt),
        .ovf_cnt    (ovf_cnt)
`endif
    );

    // Reference model: two bounded queues, frame tally and error flags.
    logic [31:0] q_in[$];
    logic [31:0] q_out[$];
    int m_frame = 0;
    bit m_fd = 0, m_udf = 0, m_ovf = 0;
    int m_udfc = 0, m_ovfc = 0;

    always @(posedge clk or negedge rst) begin
        bit pop_in, push_in, pop_out, wr_ok;
        if (!rst) begin
            q_in.delete();
            q_out.delete();
            m_frame = 0; m_fd = 0; m_udf = 0; m_ovf = 0; m_udfc = 0; m_ovfc = 0;
        end else begin
            pop_in  = req_in[0] && q_in.size() > 0;
            push_in = s_valid && q_in.size() < 128;
            pop_out = m_ready && q_out.size() > 0;
            wr_ok   = out_en[0] && q_out.size() < 128;
            if (req_in[0] && q_in.size() == 0) begin
                m_udf = 1;
                if (m_udfc < 65535) m_udfc++;
            end
            if (out_en[0] && !wr_ok) begin
                m_ovf = 1;
                if (m_ovfc < 65535) m_ovfc++;
            end
            m_fd = 0;
            if (pop_in)  void'(q_in.pop_front());
            if (push_in) q_in.push_back(32'(s_data));
            if (pop_out) void'(q_out.pop_front());
            if (wr_ok) begin
                q_out.push_back(io_out);
                m_frame++;
                if (m_frame == 128) begin
                    m_fd = 1;
                    m_frame = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every observable output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_io_in", 32'(io_in), (q_in.size() > 0) ? 32'(q_in[0][22:0]) : 32'd0);
            check("mdl_s_ready", 32'(s_ready), 32'(q_in.size() < 128));
            check("mdl_m_valid", 32'(m_valid), 32'(q_out.size() > 0));
            if (q_out.size() > 0) check("mdl_m_data", m_data, q_out[0]);
            check("mdl_frame_done", 32'(frame_done), 32'(m_fd));
            check("mdl_udf", 32'(udf), 32'(m_udf));
            check("mdl_ovf", 32'(ovf), 32'(m_ovf));
`ifdef FFT128_PORT_CNT_EN
            check("mdl_udf_cnt", 32'(udf_cnt), 32'(m_udfc));
            check("mdl_ovf_cnt", 32'(ovf_cnt), 32'(m_ovfc));
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int fd_cnt;
    int fd_at;

    initial begin
        rst = 1'b0; s_data = '0; s_valid = 1'b0; req_in = '0;
        io_out = '0; out_en = '0; m_ready = 1'b0;
        tick(); tick();
        chk_en = 1'b1;

        // Reset state
        check("rst_io_in", 32'(io_in), 0);
        check("rst_s_ready", 32'(s_ready), 1);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_udf", 32'(udf), 0);
        check("rst_ovf", 32'(ovf), 0);
        rst = 1'b1;
        tick();

        // Fill input FIFO with 0..127, then drain; a push while full is refused
        for (int i = 0; i < 128; i++) begin
            s_valid = 1'b1; s_data = 23'(i);
            tick();
        end
        s_valid = 1'b0;
        check("full_s_ready", 32'(s_ready), 0);
        for (int i = 0; i < 128; i++) begin
            check("drain_io_in", 32'(io_in), i);
            req_in = 5'b00001;
            s_valid = (i == 0);
            s_data = 23'd200;
            tick();
        end
        req_in = '0; s_valid = 1'b0;
        check("drained_io_in", 32'(io_in), 0);
        check("drained_udf", 32'(udf), 0);
        check("drained_s_ready", 32'(s_ready), 1);

        // Underflow on empty, then a push of 5 shows at the head
        req_in = 5'b00001;
        tick();
        req_in = '0;
        check("udf_set", 32'(udf), 1);
        check("udf_io_in", 32'(io_in), 0);
        s_valid = 1'b1; s_data = 23'd5;
        tick();
        s_valid = 1'b0;
        check("after_udf_io_in", 32'(io_in), 5);
        req_in = 5'b11110;
        tick();
        check("foreign_req_ignored", 32'(io_in), 5);
        req_in = 5'b00001;
        tick();
        req_in = '0;
        check("pop5_io_in", 32'(io_in), 0);
        out_en = 6'b111110; io_out = 32'd4444;
        tick();
        out_en = '0;
        check("foreign_out_en_ignored", 32'(m_valid), 0);

        // Fill output FIFO: one frame_done on write 128, write 129 dropped
        m_ready = 1'b0; fd_cnt = 0; fd_at = -1;
        for (int i = 0; i < 128; i++) begin
            out_en = 6'b000001; io_out = 32'(1000 + i);
            tick();
            if (frame_done) begin fd_cnt++; fd_at = i; end
        end
        check("frame_pulses", 32'(fd_cnt), 1);
        check("frame_pulse_at", 32'(fd_at), 127);
        check("pre_ovf", 32'(ovf), 0);
        io_out = 32'd77777;
        tick();
        out_en = '0;
        check("ovf_set", 32'(ovf), 1);
        check("ovf_no_frame", 32'(frame_done), 0);
        m_ready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            check("out_drain_data", m_data, 32'(1000 + i));
            tick();
        end
        m_ready = 1'b0;
        check("out_drained_valid", 32'(m_valid), 0);

        // Simultaneous push/pop at occupancy 64 for 100 cycles
        for (int i = 0; i < 64; i++) begin
            s_valid = 1'b1; s_data = 23'(300 + i);
            tick();
        end
        for (int k = 0; k < 100; k++) begin
            check("steady_io_in", 32'(io_in), (k < 64) ? 32'(300 + k) : 32'(400 + k - 64));
            s_valid = 1'b1; s_data = 23'(400 + k); req_in = 5'b00001;
            tick();
        end
        s_valid = 1'b0;
        for (int k = 0; k < 64; k++) begin
            check("steady_tail_io_in", 32'(io_in), 32'(436 + k));
            req_in = 5'b00001;
            tick();
        end
        req_in = '0;
        check("steady_empty", 32'(io_in), 0);

        // Reset mid-frame after 70 writes; the next 128 writes give one frame_done
        for (int i = 0; i < 70; i++) begin
            out_en = 6'b000001; io_out = 32'(2000 + i);
            tick();
        end
        out_en = '0;
        #2 rst = 1'b0;
        tick();
        check("midrst_m_valid", 32'(m_valid), 0);
        check("midrst_udf", 32'(udf), 0);
        check("midrst_ovf", 32'(ovf), 0);
        check("midrst_s_ready", 32'(s_ready), 1);
        rst = 1'b1;
        tick();
        m_ready = 1'b1; fd_cnt = 0; fd_at = -1;
        for (int i = 0; i < 128; i++) begin
            out_en = 6'b000001; io_out = 32'(3000 + i);
            tick();
            if (frame_done) begin fd_cnt++; fd_at = i; end
        end
        out_en = '0;
        check("postrst_frame_pulses", 32'(fd_cnt), 1);
        check("postrst_frame_at", 32'(fd_at), 127);
        tick();
        m_ready = 1'b0;
        check("postrst_empty", 32'(m_valid), 0);

`ifdef FFT128_PORT_CNT_EN
        // Event counters: 3 underflows, 2 overflows
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            req_in = 5'b00001;
            tick();
        end
        req_in = '0;
        for (int i = 0; i < 130; i++) begin
            out_en = 6'b000001; io_out = 32'(i);
            tick();
        end
        out_en = '0;
        check("udf_cnt", 32'(udf_cnt), 3);
        check("ovf_cnt", 32'(ovf_cnt), 2);
`endif

        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft128_port.md
FFT128_PORT -- requirements
Module: fft128_port

Interface
REQ-001 Parameter DW_IN, default 23, width of integer samples presented to the processor input port.
REQ-002 Parameter DW_OUT, default 32, width of integer results taken from the processor output port.
REQ-003 Parameter DEPTH, default 128, entries per FIFO (power of two, frame length).
REQ-004 Parameters NUIOIN default 5 and NUIOOU default 6: widths of the one-hot strobe vectors; PORT_IN default 0 and PORT_OUT default 0: the strobe bits this block answers.
REQ-005 Reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 s_data  in  DW_IN  sample from upstream source.
REQ-009 s_valid / s_ready  in / out  1 each  upstream handshake; transfer when both high.
REQ-010 io_in  out  DW_IN  signed sample driven to processor input port.
REQ-011 req_in  in  NUIOIN  processor read strobes; bit PORT_IN selects this block.
REQ-012 io_out  in  DW_OUT  signed processor result.
REQ-013 out_en  in  NUIOOU  processor write strobes; bit PORT_OUT selects this block.
REQ-014 m_data / m_valid / m_ready  out DW_OUT / out 1 / in 1  downstream result handshake.
REQ-015 frame_done  out  1  one-cycle pulse when the DEPTH-th result of a frame is captured.
REQ-016 udf / ovf  out  1 each  sticky underflow (read on empty) and overflow (write on full) flags.

Function
REQ-017 Input FIFO is show-ahead; io_in SHALL equal the head entry whenever non-empty, and 0 when empty.
REQ-018 req_in[PORT_IN] high on a non-empty FIFO SHALL pop the head at that edge; the next entry appears on io_in the following cycle.
REQ-019 req_in[PORT_IN] high on an empty FIFO SHALL not change pointers, SHALL set udf, and io_in SHALL remain 0.
REQ-020 s_ready SHALL be high iff the input FIFO is not full; simultaneous push and pop on a full FIFO SHALL be accepted only as a pop (s_ready low).
REQ-021 Simultaneous push and pop on a non-empty, non-full FIFO SHALL leave the count unchanged.
REQ-022 out_en[PORT_OUT] high SHALL write io_out into the output FIFO at that edge if not full; if full the word is dropped and ovf SET.
REQ-023 m_valid SHALL be high iff the output FIFO is non-empty; m_data is the head; pop on m_valid and m_ready.
REQ-024 A frame counter (log2 DEPTH + 1 bits) SHALL count accepted result writes; on reaching DEPTH it SHALL pulse frame_done and wrap to 0 in the same cycle.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; full/empty derived from an extra pointer MSB.
REQ-026 Strobe bits other than PORT_IN/PORT_OUT SHALL be ignored.

Reset
REQ-027 Asserting rst at any time SHALL empty both FIFOs, zero frame counter, clear udf/ovf, drive io_in=0, m_valid=0, s_ready=1, frame_done=0; FIFO memory contents need not be cleared.

Configuration
REQ-028 Macro FFT128_PORT_CNT_EN defined: add outputs udf_cnt and ovf_cnt (16 bits each, saturating at 0xFFFF, cleared by reset) counting every underflow/overflow event.
REQ-029 Macro undefined: those ports and counters SHALL not exist; sticky flags alone remain.

Structure
REQ-030 Package fft128_port_pkg SHALL hold default widths, DEPTH, pointer-width function and counter width constants.
REQ-031 Both FIFOs SHALL be instances of one sub-module, port_fifo (show-ahead, parameterized width/depth, full/empty/count outputs).

Verification
REQ-032 Push 128 samples 0..127, then strobe req_in[0] 128 cycles -> io_in reads 0..127 in order, then 0 with udf=0.
REQ-033 Strobe req_in[0] on empty FIFO -> udf=1, io_in=0, no pointer change; next pushed value 5 appears on io_in.
REQ-034 Fill output FIFO via 128 out_en[0] writes with m_ready=0 -> frame_done pulses once on write 128; write 129 sets ovf, word lost.
REQ-035 Simultaneous s_valid push and req_in pop at count 64 for 100 cycles -> count stays 64, data order preserved.
REQ-036 Assert rst mid-frame at write 70 -> m_valid=0, counter 0; next 128 writes produce exactly one frame_done.
REQ-037 With FFT128_PORT_CNT_EN, 3 underflows and 2 overflows -> udf_cnt=3, ovf_cnt=2.
